// File: rtl/ssd_scan.sv
// Multiplexed seven-segment scanner: hex decode, decimal point, blank, blink and
// leading-zero suppression, with display data double-buffered at frame boundaries.
module ssd_scan #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int BLINK_FRAMES   = 125,
   parameter int BIT_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   blank_in,
   input  logic [DIGITS-1:0]   blink_in,
   input  logic                lzs_en,
   input  logic                load,
   output logic [DIGITS-1:0]   bit_o,
   output logic [6:0]          seg,
   output logic                dp,
   output logic                frame_done
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0]     CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
   localparam logic [FW-1:0]     FRM_MAX = FW'(BLINK_FRAMES - 1);
   localparam logic [DIGITS-1:0] BIT_OFF = {DIGITS{BIT_ACTIVE_LOW != 0}};
   localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};

   typedef struct packed {
      logic [4*DIGITS-1:0] val;
      logic [DIGITS-1:0]   dp;
      logic [DIGITS-1:0]   blank;
      logic [DIGITS-1:0]   blink;
   } disp_t;

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [FW-1:0]     frm_q, frm_d;
   logic              phase_q, phase_d;
   logic              pend_q, pend_d;
   disp_t             pnd_q, pnd_d;
   disp_t             shd_q, shd_d;
   logic [DIGITS-1:0] bit_q, bit_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              fd_q, fd_d;
   logic              tick, wrap, dark, zero_run;
   logic [DIGITS-1:0] lz;
   logic [3:0]        nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   assign tick = (cnt_q == CNT_MAX);
   assign wrap = tick && (idx_q == IDX_MAX);

   always_comb begin
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      frm_d   = frm_q;
      phase_d = phase_q;
      pnd_d   = pnd_q;
      pend_d  = pend_q;
      shd_d   = shd_q;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
      if (wrap) begin
         if (frm_q == FRM_MAX) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
      // Swap uses the data pending before this edge; a coincident load re-arms pend.
      if (wrap && pend_q) begin
         shd_d  = pnd_q;
         pend_d = 1'b0;
      end
      if (load) begin
         pnd_d.val   = value;
         pnd_d.dp    = dp_in;
         pnd_d.blank = blank_in;
         pnd_d.blink = blink_in;
         pend_d      = 1'b1;
      end
   end

   // lz[i]: this nibble and every higher one are zero; digit 0 never qualifies.
   always_comb begin
      zero_run = 1'b1;
      lz       = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (shd_d.val[4*i +: 4] == 4'h0);
         lz[i]    = zero_run && (i != 0);
      end
   end

   // Outputs are built from next-state values so they land together with idx.
   always_comb begin
      nib   = shd_d.val[4*idx_d +: 4];
      dark  = shd_d.blank[idx_d] | (shd_d.blink[idx_d] & phase_d) | (lzs_en & lz[idx_d]);
      bit_d = bit_q;
      seg_d = seg_q;
      dp_d  = dp_q;
      fd_d  = wrap;
      if (tick) begin
         bit_d = BIT_OFF ^ (DIGITS'(1) << idx_d);
         seg_d = SEG_OFF ^ (dark ? 7'h00 : hex7(nib));
         dp_d  = SEG_OFF[0] ^ (shd_d.dp[idx_d] & ~dark);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
         pend_q  <= 1'b0;
         pnd_q   <= '0;
         shd_q   <= '0;
         bit_q   <= BIT_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= SEG_OFF[0];
         fd_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         pnd_q   <= pnd_d;
         shd_q   <= shd_d;
         bit_q   <= bit_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fd_q    <= fd_d;
      end
   end

   assign bit_o      = bit_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;
endmodule
